// File: rtl/div16_seq.sv
// div16_seq: sequential 16-bit unsigned restoring divider that time-shares an external ripple subtractor
module div16_seq #(
  parameter int WIDTH = 16,
  parameter int ADD_WAIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  input  logic [WIDTH-1:0] sub_s,
  input  logic             sub_cout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] r, q, d;
  logic [3:0] bit_cnt, wait_cnt;
  logic dz, accept, commit, last;
  // Subtractor operands come straight from registers so they stay put for the whole settle window
  assign sub_a = {r[WIDTH-2:0], q[WIDTH-1]};
  assign sub_b = d;
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Next state: start is honoured in IDLE and DONE, RUN ends on the commit of the last bit
  always_comb
    state_nx = (state == IDLE) ? (start ? RUN : IDLE)
             : (state == RUN)  ? ((commit && last) ? DONE : RUN)
             : (start ? RUN : IDLE);
  // Control decode: start acceptance, commit at the end of each settle window, last-bit detect
  always_comb begin
    accept = start && (state == IDLE || state == DONE);
    commit = (state == RUN) && (wait_cnt == 4'(ADD_WAIT));
    last = bit_cnt == 4'(WIDTH-1);
  end
  // Datapath: load operands on accept, shift one quotient bit per commit, otherwise count settle cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r <= '0;
      q <= '0;
      d <= '0;
      bit_cnt <= '0;
      wait_cnt <= '0;
      dz <= 1'b0;
    end else if (accept) begin
      r <= '0;
      q <= dividend;
      d <= divisor;
      bit_cnt <= '0;
      wait_cnt <= '0;
      dz <= divisor == '0;
    end else if (commit) begin
      r <= sub_cout ? sub_s : sub_a;
      q <= {q[WIDTH-2:0], sub_cout};
      wait_cnt <= '0;
      bit_cnt <= bit_cnt + 4'd1;
    end else if (state == RUN)
      wait_cnt <= wait_cnt + 4'd1;
  // Registered status and results; results are captured from the DONE state and held until the next one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= state == RUN;
      done <= state == DONE;
      if (state == DONE) begin
        quotient <= q;
        remainder <= r;
        div_by_zero <= dz;
      end
    end
endmodule

// File: tb/tb_div16_seq.sv
// tb_div16_seq: table, corner-case and random checks of div16_seq against plain-arithmetic expectations
module tb_div16_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [15:0] dvd0 = '0, dvs0 = '0, dvd1 = '0, dvs1 = '0;
  logic busy0, done0, dz0, busy1, done1, dz1;
  logic [15:0] quotient0, remainder0, sub_a0, sub_b0, sub_s0;
  logic [15:0] quotient1, remainder1, sub_a1, sub_b1, sub_s1;
  logic sub_cout0, sub_cout1;
  logic [16:0] p1 = '0, p2 = '0;
  int tests = 0, fails = 0;
  logic [15:0] pq = '0, pr = '0;
  logic pz = 1'b0;

  always #5 clk = ~clk;

  div16_seq #(.WIDTH(16), .ADD_WAIT(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .dividend(dvd0), .divisor(dvs0),
    .busy(busy0), .done(done0), .quotient(quotient0), .remainder(remainder0),
    .div_by_zero(dz0), .sub_a(sub_a0), .sub_b(sub_b0), .sub_s(sub_s0), .sub_cout(sub_cout0));

  div16_seq #(.WIDTH(16), .ADD_WAIT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dividend(dvd1), .divisor(dvs1),
    .busy(busy1), .done(done1), .quotient(quotient1), .remainder(remainder1),
    .div_by_zero(dz1), .sub_a(sub_a1), .sub_b(sub_b1), .sub_s(sub_s1), .sub_cout(sub_cout1));

  // External subtractor for u0: result appears two clocks after its operands
  always @(posedge clk) begin
    p1 <= {1'b0, sub_a0} + {1'b0, ~sub_b0} + 17'd1;
    p2 <= p1;
  end
  assign sub_s0 = p2[15:0];
  assign sub_cout0 = p2[16];
  // External subtractor for u1: zero delay
  assign {sub_cout1, sub_s1} = {1'b0, sub_a1} + {1'b0, ~sub_b1} + 17'd1;

  typedef struct {
    logic [15:0] a, b, q, r;
    logic z;
    bit mid, chain;
  } vec_t;
  vec_t tv[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [15:0] a, input logic [15:0] b);
    return (b == 16'd0) ? {16'hFFFF, a, 1'b1} : {a / b, a % b, 1'b0};
  endfunction

  task automatic launch0(input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    dvd0 = a; dvs0 = b; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
  endtask

  // Follows one u0 operation from the cycle after its start edge to its done pulse
  task automatic wait_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] eq,
                         input logic [15:0] er, input logic ez, input bit mid, input bit chain,
                         input logic [15:0] na, input logic [15:0] nb);
    int n = 0;
    int bc = 0;
    logic [15:0] pa;
    check("sub_a_load", sub_a0, {15'd0, a[15]});
    check("sub_b_load", sub_b0, b);
    pa = sub_a0;
    do begin
      @(posedge clk); #1;
      n++;
      if (busy0) bc++;
      if (n < 48 && n % 3 != 0) check("sub_a_window", sub_a0, pa);
      if (n < 48) check("sub_b_window", sub_b0, b);
      if (n == 20) begin
        check("quotient_hold", quotient0, pq);
        check("remainder_hold", remainder0, pr);
        check("dz_hold", dz0, pz);
      end
      if (mid && n == 10) begin start0 = 1'b1; dvd0 = ~a; dvs0 = b + 16'd3; end
      if (mid && n == 11) start0 = 1'b0;
      if (chain && n == 48) begin start0 = 1'b1; dvd0 = na; dvs0 = nb; end
      pa = sub_a0;
    end while (!done0 && n < 100);
    if (chain) start0 = 1'b0;
    check("latency", n, 49);
    check("busy_cycles", bc, 48);
    check("quotient", quotient0, eq);
    check("remainder", remainder0, er);
    check("div_by_zero", dz0, ez);
    pq = eq; pr = er; pz = ez;
    if (!chain) begin
      @(posedge clk); #1;
      check("done_single", done0, 1'b0);
      check("quotient_after", quotient0, eq);
    end
  endtask

  task automatic op1(input logic [15:0] a, input logic [15:0] b, input logic [15:0] eq,
                     input logic [15:0] er, input logic ez);
    int n = 0;
    @(posedge clk); #1;
    dvd1 = a; dvs1 = b; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done1 && n < 60);
    check("latency_w0", n, 17);
    check("quotient_w0", quotient1, eq);
    check("remainder_w0", remainder1, er);
    check("div_by_zero_w0", dz1, ez);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] m;
    logic [15:0] a, b;
    tv[0] = '{16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 1'b0};
    tv[1] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0};
    tv[2] = '{16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0, 1'b0, 1'b0};
    tv[3] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1'b0};
    tv[4] = '{16'h0010, 16'h0004, 16'h0004, 16'h0000, 1'b0, 1'b0, 1'b0};
    tv[5] = '{16'hBEEF, 16'h0123, 16'h00A7, 16'h011A, 1'b0, 1'b1, 1'b1};
    tv[6] = '{16'h0FFF, 16'h0040, 16'h003F, 16'h003F, 1'b0, 1'b0, 1'b0};
    tv[7] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0};
    tv[8] = '{16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0, 1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_quotient", quotient0, 16'd0);
    check("rst_remainder", remainder0, 16'd0);
    check("rst_dz", dz0, 1'b0);
    check("rst_sub_a", sub_a0, 16'd0);
    check("rst_sub_b", sub_b0, 16'd0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 0 || !tv[i-1].chain) launch0(tv[i].a, tv[i].b);
      wait_op(tv[i].a, tv[i].b, tv[i].q, tv[i].r, tv[i].z, tv[i].mid, tv[i].chain,
              tv[(i + 1) % 9].a, tv[(i + 1) % 9].b);
    end
    // Asynchronous reset in the middle of iteration 8
    launch0(16'h00F0, 16'h0007);
    repeat (24) @(posedge clk);
    #1 check("busy_before_rst", busy0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", busy0, 1'b0);
    check("async_quotient", quotient0, 16'd0);
    check("async_remainder", remainder0, 16'd0);
    check("async_sub_a", sub_a0, 16'd0);
    check("async_sub_b", sub_b0, 16'd0);
    repeat (2) @(posedge clk);
    #1 check("rst_held_busy", busy0, 1'b0);
    #2 rst_n = 1'b1;
    pq = '0; pr = '0; pz = 1'b0;
    launch0(16'h0009, 16'h0003);
    wait_op(16'h0009, 16'h0003, 16'd3, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      m = model(a, b);
      launch0(a, b);
      wait_op(a, b, m[32:17], m[16:1], m[0], 1'b0, 1'b0, 16'd0, 16'd0);
    end
    for (int i = 0; i < 9; i++) op1(tv[i].a, tv[i].b, tv[i].q, tv[i].r, tv[i].z);
    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 5)) : 16'($urandom >> $urandom_range(0, 15));
      m = model(a, b);
      op1(a, b, m[32:17], m[16:1], m[0]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
